win_scan_ctrl: RTL and testbench

//   Read-side sequencer for the 8x8 pixel window RAM. Counts the 64 pixel writes of a frame, then

---
 rtl/win_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_win_scan_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/win_scan_ctrl.sv
// win_scan_ctrl: read-side sequencer for the pixel window RAM.
// Counts a full frame of pixel writes, then walks every KxK window position,
// issuing RAM reads and streaming captured windows out on a valid/ready port.
module win_scan_ctrl #(
  parameter int unsigned IMG_DIM = 8,
  parameter int unsigned K       = 3,
  parameter int unsigned PIX_W   = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  pix_wr,
  output logic [2*$clog2(IMG_DIM)-1:0]          ram_addr,
  output logic                                  ram_rd_en,
  input  logic [K*K*PIX_W-1:0]                  ram_data,
  output logic [K*K*PIX_W-1:0]                  win_data,
  output logic [$clog2(IMG_DIM)-1:0]            win_x,
  output logic [$clog2(IMG_DIM)-1:0]            win_y,
  output logic                                  win_valid,
  input  logic                                  win_ready,
  output logic                                  win_last,
  output logic                                  frame_done,
  output logic                                  busy,
  output logic                                  ovr_err
);

  localparam int unsigned CW      = $clog2(IMG_DIM);
  localparam int unsigned WIN_W   = K * K * PIX_W;
  localparam int unsigned NPIX    = IMG_DIM * IMG_DIM;
  localparam int unsigned CNT_W   = $clog2(NPIX) + 1;
  localparam logic [CW-1:0] POS_MAX = CW'(IMG_DIM - K);

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic [CNT_W-1:0] pix_cnt_q,    pix_cnt_d;
  logic [CW-1:0]    pos_x_q,      pos_x_d;
  logic [CW-1:0]    pos_y_q,      pos_y_d;
  logic             a_vld_q,      a_vld_d;
  logic [CW-1:0]    a_x_q,        a_x_d;
  logic [CW-1:0]    a_y_q,        a_y_d;
  logic             a_last_q,     a_last_d;
  logic             b_vld_q,      b_vld_d;
  logic [WIN_W-1:0] win_data_q,   win_data_d;
  logic [CW-1:0]    win_x_q,      win_x_d;
  logic [CW-1:0]    win_y_q,      win_y_d;
  logic             win_last_q,   win_last_d;
  logic             frame_done_q, frame_done_d;
  logic             ovr_err_q,    ovr_err_d;

  logic pos_last_c;
  logic move_c;
  logic rd_en_c;

  // Pipeline handshake: A->B move and read-issue qualification
  always_comb begin
    pos_last_c = (pos_x_q == POS_MAX) && (pos_y_q == POS_MAX);
    move_c     = a_vld_q && (!b_vld_q || win_ready);
    rd_en_c    = (state_q == ST_SCAN) && (!a_vld_q || move_c);
  end

  // Next-state: FSM, scan position, stage A/B flags and payload
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    pos_x_d      = pos_x_q;
    pos_y_d      = pos_y_q;
    a_vld_d      = a_vld_q;
    a_x_d        = a_x_q;
    a_y_d        = a_y_q;
    a_last_d     = a_last_q;
    b_vld_d      = b_vld_q;
    win_data_d   = win_data_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    win_last_d   = win_last_q;
    frame_done_d = 1'b0;
    ovr_err_d    = ovr_err_q || (pix_wr && (state_q != ST_LOAD));

    // Stage B: load from A on move, otherwise empty on accept
    if (move_c) begin
      b_vld_d    = 1'b1;
      win_data_d = ram_data;
      win_x_d    = a_x_q;
      win_y_d    = a_y_q;
      win_last_d = a_last_q;
    end else if (b_vld_q && win_ready) begin
      b_vld_d = 1'b0;
    end

    // Stage A: tag follows the read it belongs to
    if (rd_en_c) begin
      a_vld_d  = 1'b1;
      a_x_d    = pos_x_q;
      a_y_d    = pos_y_q;
      a_last_d = pos_last_c;
    end else if (move_c) begin
      a_vld_d = 1'b0;
    end

    case (state_q)
      ST_LOAD: begin
        if (pix_wr) begin
          if (pix_cnt_q == CNT_W'(NPIX - 1)) begin
            state_d   = ST_SCAN;
            pix_cnt_d = '0;
            pos_x_d   = '0;
            pos_y_d   = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_SCAN: begin
        // Final position is not advanced so ram_addr keeps the last read address
        if (rd_en_c) begin
          if (pos_last_c) begin
            state_d = ST_DRAIN;
          end else if (pos_x_q == POS_MAX) begin
            pos_x_d = '0;
            pos_y_d = pos_y_q + CW'(1);
          end else begin
            pos_x_d = pos_x_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!a_vld_d && !b_vld_d) begin
          state_d      = ST_LOAD;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_LOAD;
      pix_cnt_q    <= '0;
      pos_x_q      <= '0;
      pos_y_q      <= '0;
      a_vld_q      <= 1'b0;
      a_x_q        <= '0;
      a_y_q        <= '0;
      a_last_q     <= 1'b0;
      b_vld_q      <= 1'b0;
      win_data_q   <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      a_vld_q      <= a_vld_d;
      a_x_q        <= a_x_d;
      a_y_q        <= a_y_d;
      a_last_q     <= a_last_d;
      b_vld_q      <= b_vld_d;
      win_data_q   <= win_data_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      win_last_q   <= win_last_d;
      frame_done_q <= frame_done_d;
      ovr_err_q    <= ovr_err_d;
    end
  end

  // Output mapping; the read strobe must react to win_ready in the same cycle
  always_comb begin
    ram_addr   = {pos_x_q, pos_y_q};
    ram_rd_en  = rd_en_c;
    win_data   = win_data_q;
    win_x      = win_x_q;
    win_y      = win_y_q;
    win_valid  = b_vld_q;
    win_last   = win_last_q;
    frame_done = frame_done_q;
    busy       = (state_q != ST_LOAD);
    ovr_err    = ovr_err_q;
  end

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Bench for win_scan_ctrl: RAM model, ready driver, scoreboard monitor.
module tb_win_scan_ctrl;

  typedef struct packed {
    logic [2:0]  x;
    logic [2:0]  y;
    logic        last;
    logic [71:0] data;
  } win_t;

  logic        clk;
  logic        rst;
  logic        pix_wr;
  logic [5:0]  ram_addr;
  logic        ram_rd_en;
  logic [71:0] ram_data;
  logic [71:0] win_data;
  logic [2:0]  win_x;
  logic [2:0]  win_y;
  logic        win_valid;
  logic        win_ready;
  logic        win_last;
  logic        frame_done;
  logic        busy;
  logic        ovr_err;

  win_scan_ctrl #(.IMG_DIM(8), .K(3), .PIX_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_wr     (pix_wr),
    .ram_addr   (ram_addr),
    .ram_rd_en  (ram_rd_en),
    .ram_data   (ram_data),
    .win_data   (win_data),
    .win_x      (win_x),
    .win_y      (win_y),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_last   (win_last),
    .frame_done (frame_done),
    .busy       (busy),
    .ovr_err    (ovr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  win_t        exp_q[$];
  logic [5:0]  addr_q[$];
  logic [7:0]  mem [64];
  int          ptr = 0;
  logic [7:0]  pix_val;
  int          model_pix = 0;
  int          rdy_mode = 0;
  bit          ramp_frame = 1'b0;
  bit          prev_last_acc = 1'b0;
  int          last_acc_cnt = 0;
  int          fd_cnt = 0;
  bit          stalled_prev = 1'b0;
  logic [71:0] held_data;
  logic [6:0]  held_pos;
  logic [71:0] ramp23;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected event", name);
  endtask

  // Window contents straight from the image: row-major KxK, element 0 in the low byte
  function automatic logic [71:0] win_of(input logic [2:0] x, input logic [2:0] y);
    logic [71:0] r;
    int a;
    r = '0;
    for (int dy = 0; dy < 3; dy++) begin
      for (int dx = 0; dx < 3; dx++) begin
        a = (int'(x) + dx) * 8 + int'(y) + dy;
        r[(dy*3+dx)*8 +: 8] = mem[a[5:0]];
      end
    end
    return r;
  endfunction

  // Pixel RAM: write pointer never resets; registered window read
  always @(posedge clk) begin
    if (pix_wr) begin
      mem[ptr[5:0]] <= pix_val;
      ptr <= (ptr + 1) % 64;
    end
    if (ram_rd_en) ram_data <= win_of(ram_addr[5:3], ram_addr[2:0]);
  end

  // Downstream ready: 0 always ready, 1 = 1,0,0,1 pattern then random, 2 = random
  initial begin : rdy_drv
    int pat_i;
    int last_mode;
    logic [3:0] rpat;
    rpat = 4'b1001;
    pat_i = 0;
    last_mode = -1;
    win_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode != last_mode) pat_i = 0;
      last_mode = rdy_mode;
      case (rdy_mode)
        0: win_ready = 1'b1;
        1: win_ready = (pat_i < 12) ? rpat[pat_i % 4] : 1'($urandom_range(0, 1));
        default: win_ready = ($urandom_range(0, 3) != 0);
      endcase
      pat_i++;
    end
  end

  // Expected frame: x inner, y outer over positions 0..5
  task automatic push_frame();
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 6; x++) begin
        win_t w;
        w.x    = 3'(x);
        w.y    = 3'(y);
        w.last = (x == 5) && (y == 5);
        w.data = win_of(w.x, w.y);
        exp_q.push_back(w);
        addr_q.push_back({w.x, w.y});
      end
    end
  endtask

  task automatic write_pixels(input int n, input bit ramp);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pix_wr  = 1'b1;
      pix_val = ramp ? 8'(ptr) : 8'($urandom);
    end
    @(posedge clk);
    #1;
    pix_wr = 1'b0;
    model_pix += n;
    if (model_pix == 64) begin
      model_pix = 0;
      push_frame();
    end
  endtask

  task automatic wait_frame();
    int start;
    start = fd_cnt;
    for (int i = 0; i < 3000 && fd_cnt == start; i++) begin
      @(negedge clk);
      #1;
    end
    if (fd_cnt == start) fail_now("frame_done_timeout");
    chk("windows_left", 80'(exp_q.size()), 80'(0));
  endtask

  task automatic wait_last_acc();
    int start;
    start = last_acc_cnt;
    for (int i = 0; i < 3000 && last_acc_cnt == start; i++) begin
      @(negedge clk);
      #1;
    end
    if (last_acc_cnt == start) fail_now("last_accept_timeout");
  endtask

  function automatic logic [79:0] all_outs();
    return 80'({ram_addr, ram_rd_en, win_data, win_x, win_y, win_valid, win_last,
                frame_done, busy, ovr_err});
  endfunction

  // Monitor: read addresses, accepts, stall stability, frame_done timing
  always @(negedge clk) begin : mon
    win_t e;
    logic acc;
    if (rst) begin
      prev_last_acc = 1'b0;
      stalled_prev  = 1'b0;
    end else begin
      if (ram_rd_en) begin
        if (addr_q.size() == 0) fail_now("unexpected_read");
        else chk("ram_addr", 80'(ram_addr), 80'(addr_q.pop_front()));
      end
      if (frame_done || prev_last_acc) chk("frame_done", 80'(frame_done), 80'(prev_last_acc));
      if (frame_done) fd_cnt++;
      if (stalled_prev) begin
        chk("stall_valid", 80'(win_valid), 80'(1));
        chk("stall_data", 80'(win_data), 80'(held_data));
        chk("stall_pos", 80'({win_x, win_y, win_last}), 80'(held_pos));
      end
      acc = win_valid && win_ready;
      if (acc) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_window");
        end else begin
          e = exp_q.pop_front();
          chk("win_data", 80'(win_data), 80'(e.data));
          chk("win_pos", 80'({win_x, win_y, win_last}), 80'({e.x, e.y, e.last}));
          if (ramp_frame && win_x == 3'd2 && win_y == 3'd3)
            chk("ramp_win_2_3", 80'(win_data), 80'(ramp23));
        end
      end
      prev_last_acc = acc && win_last;
      if (prev_last_acc) last_acc_cnt++;
      stalled_prev = win_valid && !win_ready;
      held_data    = win_data;
      held_pos     = {win_x, win_y, win_last};
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : main
    ramp23  = 72'h25_1D_15_24_1C_14_23_1B_13;
    rst     = 1'b1;
    pix_wr  = 1'b0;
    pix_val = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 80'(0));
    rst = 1'b0;

    // Ramp frame, always ready: latency, burst, contents
    rdy_mode   = 0;
    ramp_frame = 1'b1;
    write_pixels(64, 1'b1);
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      chk("rd_burst", 80'(ram_rd_en), 80'(1));
      if (i == 0) chk("busy_start", 80'(busy), 80'(1));
      if (i < 2) chk("valid_latency_lo", 80'(win_valid), 80'(0));
      if (i == 2) chk("valid_latency_hi", 80'(win_valid), 80'(1));
    end
    @(negedge clk);
    chk("rd_burst_end", 80'(ram_rd_en), 80'(0));
    wait_frame();
    ramp_frame = 1'b0;

    // Random image, ready pattern 1,0,0,1 then random stalls
    rdy_mode = 1;
    write_pixels(64, 1'b0);
    wait_last_acc();

    // Next frame starts on the frame_done cycle; stray write mid-scan
    rdy_mode = 2;
    write_pixels(64, 1'b0);
    @(negedge clk);
    chk("start_on_fd_busy", 80'(busy), 80'(1));
    chk("ovr_before", 80'(ovr_err), 80'(0));
    for (int i = 0; i < 2000 && exp_q.size() > 30; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    pix_wr  = 1'b1;
    pix_val = mem[ptr[5:0]];
    @(posedge clk);
    #1;
    pix_wr = 1'b0;
    @(negedge clk);
    chk("ovr_set", 80'(ovr_err), 80'(1));
    wait_frame();
    chk("ovr_sticky", 80'(ovr_err), 80'(1));

    // 63 writes must not start a scan
    write_pixels(63, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle63_rd", 80'(ram_rd_en), 80'(0));
      chk("idle63_busy", 80'(busy), 80'(0));
    end
    write_pixels(1, 1'b0);
    @(negedge clk);
    chk("pix64_rd", 80'(ram_rd_en), 80'(1));
    chk("pix64_busy", 80'(busy), 80'(1));
    wait_frame();

    // Reset with window 10 on the output
    rdy_mode = 0;
    write_pixels(64, 1'b0);
    for (int i = 0; i < 2000 && exp_q.size() > 26; i++) begin
      @(negedge clk);
      #1;
    end
    chk("pre_reset_valid", 80'(win_valid), 80'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", all_outs(), 80'(0));
    exp_q.delete();
    addr_q.delete();
    model_pix = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    write_pixels(64, 1'b0);
    @(negedge clk);
    chk("post_reset_addr", 80'(ram_addr), 80'(0));
    wait_frame();

    chk("addr_left", 80'(addr_q.size()), 80'(0));
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
